mmi_initiator: RTL and testbench
================================

// Module: mmi_initiator
// PURPOSE
//  Bus-initiator end of the MMI register interface. Accepts single read/write requests on a
//  valid/ready request channel and performs one MMI transaction per request against the
//  register-bank responder (mmi_valid/mmi_wstrb/addr/wdata out, mmi_ready/rdata in).
//  Returns read data and status on a valid/ready response channel. Used by the host/debug
//  path to reach the smartcard register bank without the CPU.
// PARAMETERS
//  ADDR_W   3   MMI word-address width
//  WR_BASE  3   lowest address the responder accepts writes to; lower addresses are read-only
//  TIMEOUT  15  cycles to wait for mmi_ready before abort (used only with MMI_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted this cycle when req_valid & req_ready
//  req_write    in   1       1 = write, 0 = read
//  req_addr     in   ADDR_W  target word address
//  req_wdata    in   32      write data
//  req_wstrb    in   4       byte enables for writes
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32      read data (0 for writes and errors)
//  rsp_err      out  1       1 = write to read-only address, or timeout
//  mmi_valid    out  1       MMI transaction request
//  mmi_wstrb    out  4       MMI byte strobes (0000 = read)
//  mmi_ready    in   1       MMI completion from responder
//  o_mmi_wdata  out  32      MMI write data
//  i_mmi_rdata  in   32      MMI read data, valid in the cycle mmi_ready = 1
//  o_mmi_addr   out  ADDR_W  MMI address
// BEHAVIOUR
//  - Reset (rst = 0, async): state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
//  - FSM IDLE -> BUS -> RESP -> IDLE. All outputs registered.
//  - IDLE: req_ready=1, mmi_valid=0. On accept, latch addr/wdata/wstrb/write; req_ready=0.
//      write & addr < WR_BASE: no MMI cycle; -> RESP with rsp_err=1, rsp_rdata=0.
//      otherwise -> BUS; next cycle mmi_valid=1, o_mmi_addr=addr, o_mmi_wdata=wdata,
//      mmi_wstrb = write ? wstrb : 4'b0000.
//  - BUS: hold mmi_valid and all MMI outputs stable until mmi_ready=1. On mmi_ready: capture
//      rsp_rdata = write ? 0 : i_mmi_rdata, rsp_err=0; drop mmi_valid next cycle; -> RESP.
//      Write with wstrb=0000 is issued as-is (responder treats it as read); rsp_rdata=0.
//  - RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready=1; then rsp_valid=0,
//      -> IDLE. rsp_ready while rsp_valid=0 ignored.
//  - mmi_valid is guaranteed low for >=1 cycle between transactions (RESP state), so a stale
//      mmi_ready from the previous transaction is never taken as completion.
//  - mmi_ready sampled only in BUS; ignored in IDLE/RESP.
//  - Minimum latency, accept to rsp_valid: 3 cycles with a 1-cycle responder.
//  - Throughput: one outstanding request; req_ready low from accept until response consumed.
// CONFIGURATION
//  MMI_TIMEOUT_EN defined: counter clears on entry to BUS, increments each BUS cycle without
//    mmi_ready; on reaching TIMEOUT, drop mmi_valid, -> RESP with rsp_err=1, rsp_rdata=0.
//    mmi_ready in the same cycle the count reaches TIMEOUT wins (normal completion).
//  MMI_TIMEOUT_EN undefined: no counter; BUS waits for mmi_ready indefinitely; rsp_err set
//    only for read-only-address writes.
// TESTING
//  T1 read addr 0, responder readies 1 cycle after mmi_valid with rdata 0x00A55A01 ->
//     mmi_wstrb=0000, rsp_valid 3 cycles after accept, rsp_rdata=0x00A55A01, rsp_err=0.
//  T2 write addr 3, wdata 0x12345678, wstrb 1111 -> o_mmi_addr=3, o_mmi_wdata=0x12345678,
//     mmi_wstrb=1111 held until mmi_ready; rsp_rdata=0, rsp_err=0.
//  T3 write addr 1, wstrb 1111 -> mmi_valid never asserted; rsp_valid with rsp_err=1.
//  T4 rsp_ready held low 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0,
//     new req_valid not accepted until cycle after rsp_ready=1.
//  T5 (MMI_TIMEOUT_EN) mmi_ready tied 0 -> mmi_valid drops after 15 BUS cycles, rsp_err=1;
//     without macro, mmi_valid still high after 100 cycles.
//  T6 rst=0 while in BUS -> mmi_valid, rsp_valid 0 immediately (async); req_ready=1 after
//     release; back-to-back requests show >=1 cycle mmi_valid=0 between transactions.

Source files
------------

// File: rtl/mmi_initiator.sv
// rtl/mmi_initiator.sv - MMI register-bus initiator; optional bus-wait timeout under `MMI_TIMEOUT_EN
module mmi_initiator #(
    parameter int ADDR_W  = 3,
    parameter int WR_BASE = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mmi_valid,
    output logic [3:0]        mmi_wstrb,
    input  logic              mmi_ready,
    output logic [31:0]       o_mmi_wdata,
    input  logic [31:0]       i_mmi_rdata,
    output logic [ADDR_W-1:0] o_mmi_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

`ifdef MMI_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    // Without the timeout the counter never gates anything and is trimmed away.
    localparam bit TO_EN = 1'b0;
`endif

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t              r_state,     w_state_n;
    logic                r_req_ready, w_req_ready_n;
    logic                r_rsp_valid, w_rsp_valid_n;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_n;
    logic                r_rsp_err,   w_rsp_err_n;
    logic                r_mmi_valid, w_mmi_valid_n;
    logic [3:0]          r_mmi_wstrb, w_mmi_wstrb_n;
    logic [31:0]         r_mmi_wdata, w_mmi_wdata_n;
    logic [ADDR_W-1:0]   r_mmi_addr,  w_mmi_addr_n;
    logic                r_write,     w_write_n;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_n;
    logic                w_timeout;

    // Count reaches TIMEOUT on the TIMEOUT-th BUS cycle without mmi_ready.
    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mmi_valid   = r_mmi_valid;
    assign mmi_wstrb   = r_mmi_wstrb;
    assign o_mmi_wdata = r_mmi_wdata;
    assign o_mmi_addr  = r_mmi_addr;

    // Next-state and next-output decode; every output comes straight from a register.
    always_comb begin
        w_state_n     = r_state;
        w_req_ready_n = r_req_ready;
        w_rsp_valid_n = r_rsp_valid;
        w_rsp_rdata_n = r_rsp_rdata;
        w_rsp_err_n   = r_rsp_err;
        w_mmi_valid_n = r_mmi_valid;
        w_mmi_wstrb_n = r_mmi_wstrb;
        w_mmi_wdata_n = r_mmi_wdata;
        w_mmi_addr_n  = r_mmi_addr;
        w_write_n     = r_write;
        w_cnt_n       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_req_ready_n = 1'b0;
                    w_write_n     = req_write;
                    w_cnt_n       = '0;
                    if (req_write && (req_addr < WR_BASE_A)) begin
                        // Read-only target: answer with an error, never touch the bus.
                        w_state_n     = S_RESP;
                        w_rsp_valid_n = 1'b1;
                        w_rsp_err_n   = 1'b1;
                        w_rsp_rdata_n = '0;
                    end else begin
                        w_state_n     = S_BUS;
                        w_mmi_valid_n = 1'b1;
                        w_mmi_addr_n  = req_addr;
                        w_mmi_wdata_n = req_wdata;
                        w_mmi_wstrb_n = req_write ? req_wstrb : 4'b0000;
                    end
                end
            end
            S_BUS: begin
                if (mmi_ready) begin
                    // Completion beats a timeout landing in the same cycle.
                    w_state_n     = S_RESP;
                    w_mmi_valid_n = 1'b0;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b0;
                    w_rsp_rdata_n = r_write ? 32'd0 : i_mmi_rdata;
                end else if (w_timeout) begin
                    w_state_n     = S_RESP;
                    w_mmi_valid_n = 1'b0;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b1;
                    w_rsp_rdata_n = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                // mmi_valid is already low here, so a lingering mmi_ready is harmless.
                if (rsp_ready) begin
                    w_state_n     = S_IDLE;
                    w_rsp_valid_n = 1'b0;
                    w_req_ready_n = 1'b1;
                end
            end
            default: begin
                w_state_n     = S_IDLE;
                w_req_ready_n = 1'b1;
                w_rsp_valid_n = 1'b0;
                w_mmi_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mmi_valid <= 1'b0;
            r_mmi_wstrb <= '0;
            r_mmi_wdata <= '0;
            r_mmi_addr  <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_req_ready <= w_req_ready_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_rdata <= w_rsp_rdata_n;
            r_rsp_err   <= w_rsp_err_n;
            r_mmi_valid <= w_mmi_valid_n;
            r_mmi_wstrb <= w_mmi_wstrb_n;
            r_mmi_wdata <= w_mmi_wdata_n;
            r_mmi_addr  <= w_mmi_addr_n;
            r_write     <= w_write_n;
            r_cnt       <= w_cnt_n;
        end
    end

endmodule

// File: tb/tb_mmi_initiator.sv
// tb/tb_mmi_initiator.sv - self-checking bench for mmi_initiator (honours `MMI_TIMEOUT_EN)
module tb_mmi_initiator;

    localparam int WR_BASE = 3;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mmi_valid, mmi_ready;
    logic [3:0]  mmi_wstrb;
    logic [31:0] o_mmi_wdata, i_mmi_rdata;
    logic [2:0]  o_mmi_addr;

    int n_tests = 0;
    int n_fail  = 0;

    mmi_initiator #(.ADDR_W(3), .WR_BASE(WR_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mmi_valid(mmi_valid), .mmi_wstrb(mmi_wstrb), .mmi_ready(mmi_ready),
        .o_mmi_wdata(o_mmi_wdata), .i_mmi_rdata(i_mmi_rdata), .o_mmi_addr(o_mmi_addr)
    );

    always #5 clk = ~clk;

    // One complete request/response; inputs change and outputs are sampled on negedges.
    task automatic test_txn(input string name, input logic wr, input logic [2:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                            input int rdy_dly, input int hold, input bit stale, input bit poke);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_ws;
        exp_err = wr && (int'(addr) < WR_BASE);
        exp_rd  = (wr || exp_err) ? 32'd0 : rd;
        exp_ws  = wr ? ws : 4'b0000;

        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_req_ready: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 3'($urandom);
        req_wdata = $urandom; req_wstrb = 4'($urandom);

        if (!exp_err) begin
            for (int c = 0; c < rdy_dly; c++) begin
                n_tests++;
                if ({mmi_valid, o_mmi_addr, o_mmi_wdata, mmi_wstrb, rsp_valid, req_ready} !==
                    {1'b1, addr, wd, exp_ws, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s bus_c%0d: got v=%b a=%h d=%h s=%b rv=%b rr=%b want v=1 a=%h d=%h s=%b rv=0 rr=0",
                             name, c, mmi_valid, o_mmi_addr, o_mmi_wdata, mmi_wstrb, rsp_valid,
                             req_ready, addr, wd, exp_ws);
                end
                rsp_ready = (c == rdy_dly - 1) ? 1'b0 : 1'($urandom);
                if (c == rdy_dly - 1) begin
                    mmi_ready = 1'b1;
                    i_mmi_rdata = rd;
                end
                @(negedge clk);
            end
            mmi_ready = stale;
            i_mmi_rdata = $urandom;
        end

        for (int c = 0; c <= hold; c++) begin
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_rdata, mmi_valid, req_ready} !==
                {1'b1, exp_err, exp_rd, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s resp_c%0d: got rv=%b e=%b d=%h mv=%b rr=%b want rv=1 e=%b d=%h mv=0 rr=0",
                         name, c, rsp_valid, rsp_err, rsp_rdata, mmi_valid, req_ready, exp_err, exp_rd);
            end
            if (c == 0 && poke) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
            end
            if (c == hold) rsp_ready = 1'b1;
            @(negedge clk);
            mmi_ready = 1'b0;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_tests++;
        if ({rsp_valid, req_ready, mmi_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s after_rsp: got rv=%b rr=%b mv=%b want rv=0 rr=1 mv=0",
                     name, rsp_valid, req_ready, mmi_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mmi_valid, mmi_wstrb, o_mmi_wdata, o_mmi_addr} !==
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rr=%b rv=%b d=%h e=%b mv=%b s=%b wd=%h a=%h want rr=1 rest 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mmi_valid, mmi_wstrb, o_mmi_wdata, o_mmi_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        test_txn("t1_read", 1'b0, 3'd0, 32'hDEAD_BEEF, 4'hF, 32'h00A5_5A01, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_write();
        test_txn("t2_write", 1'b1, 3'd3, 32'h1234_5678, 4'b1111, 32'hFFFF_FFFF, 3, 0, 1'b0, 1'b0);
        test_txn("t2_wstrb0", 1'b1, 3'd7, 32'hCAFE_0000, 4'b0000, 32'h5555_AAAA, 2, 1, 1'b1, 1'b0);
    endtask

    task automatic test_ro_write();
        test_txn("t3_ro_a1", 1'b1, 3'd1, 32'h0BAD_0001, 4'b1111, 32'h0, 1, 0, 1'b0, 1'b0);
        test_txn("t3_ro_a2", 1'b1, 3'd2, 32'h0BAD_0002, 4'b0101, 32'h0, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        test_txn("t4_hold", 1'b0, 3'd5, 32'h0, 4'h0, 32'h7777_1234, 2, 5, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        int high;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd6; req_wstrb = 4'h0;
        @(negedge clk);
        req_valid = 1'b0;
        mmi_ready = 1'b0;
        high = 0;
`ifdef MMI_TIMEOUT_EN
        for (int c = 0; c < 40 && mmi_valid; c++) begin
            high++;
            @(negedge clk);
        end
        n_tests++;
        if (high != TIMEOUT) begin
            n_fail++;
            $display("FAIL t5_timeout_len: got %0d want %0d", high, TIMEOUT);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL t5_timeout_rsp: got rv=%b e=%b d=%h want rv=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata);
        end
`else
        for (int c = 0; c < 100; c++) begin
            if (mmi_valid === 1'b1) high++;
            @(negedge clk);
        end
        n_tests++;
        if (high != 100 || mmi_valid !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_no_timeout: got high=%0d mv=%b rv=%b want high=100 mv=1 rv=0", high, mmi_valid, rsp_valid);
        end
        mmi_ready = 1'b1; i_mmi_rdata = 32'h0000_0100;
        @(negedge clk);
        mmi_ready = 1'b0;
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL t5_late_rsp: got rv=%b e=%b d=%h want rv=1 e=0 d=00000100", rsp_valid, rsp_err, rsp_rdata);
        end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        // Ready arriving exactly on the last permitted BUS cycle must still complete normally.
        test_txn("t5_edge", 1'b0, 3'd3, 32'h0, 4'h0, 32'h1357_9BDF, TIMEOUT, 0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if (mmi_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_in_bus: got mv=%b want 1", mmi_valid);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({mmi_valid, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL t6_async: got mv=%b rv=%b rr=%b want mv=0 rv=0 rr=1", mmi_valid, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mmi_valid, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL t6_release: got mv=%b rv=%b rr=%b want mv=0 rv=0 rr=1", mmi_valid, rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            logic [3:0] ws;
            ws = (i % 7 == 0) ? 4'b0000 : 4'($urandom);
            test_txn($sformatf("b2b_%0d", i), 1'($urandom), 3'($urandom), $urandom, ws, $urandom,
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0; mmi_ready = 1'b0; i_mmi_rdata = '0;
        @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_ro_write();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
